// File: rtl/chess_clock_timer_if.sv
// rtl/chess_clock_timer_if.sv - FSM <-> time-keeping datapath signal bundle
//
// Purpose : groups the control inputs and time/flag outputs of the chess
//           clock timer so the FSM side and the timer side each take one port.
// Signals :
//   i_restart        load both times from i_cfg_time
//   i_cfg_time       initial seconds per player (TIME_W)
//   i_cfg_inc        Fischer increment in seconds (INC_W)
//   i_player_a_stop  low: player A's time runs
//   i_player_b_stop  low: player B's time runs
//   o_time_a/b       remaining seconds per player (registered)
//   o_player_a/b_zero high while the matching time is 0
//   o_sec_pulse      one-cycle pulse on every decrement
// Modports: master = FSM / display side, slave = timer datapath.

interface chess_clock_timer_if #(
    parameter int TIME_W = 12,
    parameter int INC_W  = 6
);
    logic              i_restart;
    logic [TIME_W-1:0] i_cfg_time;
    logic [INC_W-1:0]  i_cfg_inc;
    logic              i_player_a_stop;
    logic              i_player_b_stop;
    logic [TIME_W-1:0] o_time_a;
    logic [TIME_W-1:0] o_time_b;
    logic              o_player_a_zero;
    logic              o_player_b_zero;
    logic              o_sec_pulse;

    modport master (
        output i_restart, i_cfg_time, i_cfg_inc, i_player_a_stop, i_player_b_stop,
        input  o_time_a, o_time_b, o_player_a_zero, o_player_b_zero, o_sec_pulse
    );

    modport slave (
        input  i_restart, i_cfg_time, i_cfg_inc, i_player_a_stop, i_player_b_stop,
        output o_time_a, o_time_b, o_player_a_zero, o_player_b_zero, o_sec_pulse
    );
endinterface

// File: rtl/chess_clock_timer.sv
// rtl/chess_clock_timer.sv - per-player seconds countdown with Fischer increment
//
// Purpose : keeps each player's remaining whole seconds, counts down the
//           player the FSM enables, adds the increment on hand-over and
//           reports zero flags back to the FSM.
// Ports   :
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset (times clear to 0)
//   bus      chess_clock_timer_if.slave: restart/config/stop inputs,
//            time/zero/second-pulse outputs

module chess_clock_timer #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int TIME_W        = 12,
    parameter int INC_W         = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    chess_clock_timer_if.slave    bus
);

    localparam int PS_W  = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SUM_W = ((TIME_W > INC_W) ? TIME_W : INC_W) + 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICKS_PER_SEC - 1);
    localparam logic [SUM_W-1:0] TIME_MAX = {{(SUM_W-TIME_W){1'b0}}, {TIME_W{1'b1}}};

    logic [PS_W-1:0]   prescaler_q, prescaler_d;
    logic [TIME_W-1:0] time_a_q, time_a_d;
    logic [TIME_W-1:0] time_b_q, time_b_d;
    logic              run_a_q, run_a_d;
    logic              run_b_q, run_b_d;
    logic              sec_pulse_q, sec_pulse_d;

    logic run_a, run_b;
    logic handover_ab, handover_ba;

    // Adds the increment in a widened sum so a large increment clamps to
    // the counter maximum instead of wrapping to a small time.
    function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] t,
                                                 input logic [INC_W-1:0]  inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(t) + SUM_W'(inc);
        if (sum > TIME_MAX) begin
            return {TIME_W{1'b1}};
        end
        return sum[TIME_W-1:0];
    endfunction

    always_comb begin
        run_a = ~bus.i_player_a_stop & (time_a_q != '0);
        run_b = ~bus.i_player_b_stop & (time_b_q != '0) & ~run_a;

        // A hand-over is the outgoing player stopping while the other starts.
        // A player already at zero earns no increment for handing over.
        handover_ab = run_a_q & bus.i_player_a_stop & ~bus.i_player_b_stop & (time_a_q != '0);
        handover_ba = run_b_q & bus.i_player_b_stop & ~bus.i_player_a_stop & (time_b_q != '0);
    end

    always_comb begin
        prescaler_d = prescaler_q;
        time_a_d    = time_a_q;
        time_b_d    = time_b_q;
        run_a_d     = ~bus.i_player_a_stop;
        run_b_d     = ~bus.i_player_b_stop;
        sec_pulse_d = 1'b0;

        if (bus.i_restart) begin
            time_a_d    = bus.i_cfg_time;
            time_b_d    = bus.i_cfg_time;
            prescaler_d = '0;
            run_a_d     = 1'b0;
            run_b_d     = 1'b0;
        end else if (handover_ab) begin
            // Clearing the prescaler gives the incoming player a full second.
            time_a_d    = sat_add(time_a_q, bus.i_cfg_inc);
            prescaler_d = '0;
        end else if (handover_ba) begin
            time_b_d    = sat_add(time_b_q, bus.i_cfg_inc);
            prescaler_d = '0;
        end else if (run_a | run_b) begin
            if (prescaler_q == PS_LAST) begin
                prescaler_d = '0;
                sec_pulse_d = 1'b1;
                if (run_a) begin
                    time_a_d = time_a_q - TIME_W'(1);
                end else begin
                    time_b_d = time_b_q - TIME_W'(1);
                end
            end else begin
                prescaler_d = prescaler_q + PS_W'(1);
            end
        end
        // Otherwise hold: a paused player resumes mid-second.
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prescaler_q <= '0;
            time_a_q    <= '0;
            time_b_q    <= '0;
            run_a_q     <= 1'b0;
            run_b_q     <= 1'b0;
            sec_pulse_q <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            time_a_q    <= time_a_d;
            time_b_q    <= time_b_d;
            run_a_q     <= run_a_d;
            run_b_q     <= run_b_d;
            sec_pulse_q <= sec_pulse_d;
        end
    end

    assign bus.o_time_a        = time_a_q;
    assign bus.o_time_b        = time_b_q;
    assign bus.o_player_a_zero = (time_a_q == '0);
    assign bus.o_player_b_zero = (time_b_q == '0);
    assign bus.o_sec_pulse     = sec_pulse_q;

endmodule
